// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad pins and decoded key outputs of keypad_scanner
interface keypad_scanner_if;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   // master: the scanner, which drives the columns and reports keys
   modport master (input row, output col, key_code, key_valid, key_held);
   // slave: the keypad side / consumer of the key reports
   modport slave  (output row, input col, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce
module keypad_scanner #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 1000000
) (
   input logic              clk,
   input logic              reset,
   keypad_scanner_if.master kp
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   // The sample that starts a debounce already counts as the first stable one,
   // so the counter only has to cover the remaining DEBOUNCE_CNT-1 samples.
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 2);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   state_t          state_q;
   logic [3:0]      row_meta_q;
   logic [3:0]      row_s_q;
   logic [3:0]      col_q;
   logic [DW-1:0]   dwell_q;
   logic [CW-1:0]   deb_cnt_q;
   logic [1:0]      key_row_q;
   logic [3:0]      key_code_q;
   logic            key_valid_q;
   logic            key_held_q;

   logic [1:0]      col_idx;
   logic [1:0]      low_row;
   logic            key_level;
   logic [3:0]      map_code;

   // Two-flop synchronizer for the asynchronous row pins; idles as "no key".
   always_ff @(posedge clk) begin
      if (reset) begin
         row_meta_q <= 4'hF;
         row_s_q    <= 4'hF;
      end else begin
         row_meta_q <= kp.row;
         row_s_q    <= row_meta_q;
      end
   end

   // Column index of the driven column, lowest low row, tracked row level and key map.
   always_comb begin
      col_idx = 2'd0;
      for (int c = 0; c < 4; c++)
         if (!col_q[c]) col_idx = 2'(c);
      low_row = 2'd0;
      for (int r = 3; r >= 0; r--)
         if (!row_s_q[r]) low_row = 2'(r);
      key_level = row_s_q[key_row_q];
      case ({col_idx, key_row_q})
         4'h0: map_code = 4'h1;
         4'h1: map_code = 4'h4;
         4'h2: map_code = 4'h7;
         4'h3: map_code = 4'h0;
         4'h4: map_code = 4'h2;
         4'h5: map_code = 4'h5;
         4'h6: map_code = 4'h8;
         4'h7: map_code = 4'hF;
         4'h8: map_code = 4'h3;
         4'h9: map_code = 4'h6;
         4'hA: map_code = 4'h9;
         4'hB: map_code = 4'hE;
         4'hC: map_code = 4'hA;
         4'hD: map_code = 4'hB;
         4'hE: map_code = 4'hC;
         default: map_code = 4'hD;
      endcase
   end

   // Scan / debounce / held / release controller with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         col_q       <= 4'b1110;
         dwell_q     <= '0;
         deb_cnt_q   <= '0;
         key_row_q   <= 2'd0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         case (state_q)
            SCAN: begin
               if (dwell_q == DWELL_LAST) begin
                  dwell_q <= '0;
                  if (row_s_q != 4'hF) begin
                     key_row_q <= low_row;
                     deb_cnt_q <= '0;
                     state_q   <= DEBOUNCE;
                  end else begin
                     col_q <= {col_q[2:0], col_q[3]};
                  end
               end else begin
                  dwell_q <= dwell_q + DW'(1);
               end
            end
            DEBOUNCE: begin
               if (key_level) begin
                  // Bounce or glitch: give up and move on to the next column.
                  col_q   <= {col_q[2:0], col_q[3]};
                  dwell_q <= '0;
                  state_q <= SCAN;
               end else if (deb_cnt_q == DEB_LAST) begin
                  key_code_q  <= map_code;
                  key_valid_q <= 1'b1;
                  key_held_q  <= 1'b1;
                  state_q     <= HELD;
               end else begin
                  deb_cnt_q <= deb_cnt_q + CW'(1);
               end
            end
            HELD: begin
               if (key_level) begin
                  deb_cnt_q <= '0;
                  state_q   <= RELEASE;
               end
            end
            default: begin
               if (!key_level) begin
                  state_q <= HELD;
               end else if (deb_cnt_q == DEB_LAST) begin
                  key_held_q <= 1'b0;
                  col_q      <= {col_q[2:0], col_q[3]};
                  dwell_q    <= '0;
                  state_q    <= SCAN;
               end else begin
                  deb_cnt_q <= deb_cnt_q + CW'(1);
               end
            end
         endcase
      end
   end

   assign kp.col       = col_q;
   assign kp.key_code  = key_code_q;
   assign kp.key_valid = key_valid_q;
   assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner
module tb_keypad_scanner;

   localparam int SD = 8;
   localparam int DB = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] keys = 16'h0;   // keys[c*4+r] = key at column c, row r pressed

   always #5 clk = ~clk;

   keypad_scanner_if kif();

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
      .clk   (clk),
      .reset (reset),
      .kp    (kif)
   );

   // Physical keypad: a pressed key shorts its row to its column when driven low.
   always_comb begin
      kif.row = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (keys[c*4+r] && kif.col[c] == 1'b0) kif.row[r] = 1'b0;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Key legend: digits 1..9 fill the upper 3x3 block row-major, column 3 holds A..D,
   // bottom row of columns 0..2 holds 0, F, E.
   function automatic logic [3:0] code_of(input int c, input int r);
      if (c == 3) return 4'(10 + r);
      if (r == 3) return (c == 0) ? 4'h0 : (c == 1) ? 4'hF : 4'hE;
      return 4'(r * 3 + c + 1);
   endfunction

   function automatic logic [3:0] pins_of(input logic [15:0] k, input int c);
      logic [3:0] p;
      p = 4'hF;
      for (int r = 0; r < 4; r++)
         if (k[c*4+r]) p[r] = 1'b0;
      return p;
   endfunction

   function automatic int first_low(input logic [3:0] v);
      for (int r = 0; r < 4; r++)
         if (!v[r]) return r;
      return 0;
   endfunction

   // Reference model: time-based scan position, a tracked key and a stable-run length.
   bit         m_init = 1'b0;
   int         t, base_t, base_col, trk_c, trk_r, run, m_col_idx;
   bit         acc;
   logic [3:0] m_p1, m_p2, m_code;
   bit         m_valid, m_held;

   int         n_pulse = 0;
   logic [3:0] seen_code = 4'h0;

   task automatic m_resume();
      base_col = (trk_c + 1) % 4;
      base_t   = t + 1;
      trk_c    = -1;
      run      = 0;
      acc      = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [3:0] rs, pin, ecol;
      if (m_init) begin
         ecol = 4'hF;
         ecol[m_col_idx] = 1'b0;
         check("col", kif.col, ecol);
         check("key_valid", kif.key_valid, m_valid);
         check("key_held", kif.key_held, m_held);
         check("key_code", kif.key_code, m_code);
         if (kif.key_valid) begin
            n_pulse++;
            seen_code = kif.key_code;
         end
      end
      if (reset) begin
         t = 0; base_t = 0; base_col = 0; trk_c = -1; trk_r = 0; run = 0; acc = 1'b0;
         m_p1 = 4'hF; m_p2 = 4'hF; m_col_idx = 0;
         m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
         m_init = 1'b1;
      end else if (m_init) begin
         rs  = m_p2;
         pin = pins_of(keys, m_col_idx);
         m_valid = 1'b0;
         if (trk_c < 0) begin
            if ((t - base_t) % SD == SD - 1 && rs != 4'hF) begin
               trk_c = m_col_idx; trk_r = first_low(rs); run = 1; acc = 1'b0;
            end
         end else if (!acc) begin
            if (!rs[trk_r]) begin
               run++;
               if (run == DB) begin
                  acc = 1'b1; run = 0;
                  m_valid = 1'b1; m_held = 1'b1; m_code = code_of(trk_c, trk_r);
               end
            end else begin
               m_resume();
            end
         end else begin
            if (rs[trk_r]) begin
               run++;
               if (run == DB) begin
                  m_held = 1'b0;
                  m_resume();
               end
            end else begin
               run = 0;
            end
         end
         m_p2 = m_p1;
         m_p1 = pin;
         t++;
         if (trk_c < 0) m_col_idx = (base_col + (t - base_t) / SD) % 4;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int k, mode;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(1);
      check("rst_col", kif.col, 4'b1110);
      check("rst_valid", kif.key_valid, 1'b0);
      check("rst_held", kif.key_held, 1'b0);
      check("rst_code", kif.key_code, 4'h0);
      tick(40);

      // clean press of "5"
      n_pulse = 0;
      keys[1*4+1] = 1'b1;
      tick(200);
      keys = 16'h0;
      tick(60);
      check("p5_count", n_pulse, 1);
      check("p5_code", seen_code, 4'h5);
      check("p5_released", kif.key_held, 1'b0);

      // bouncy press of "E"
      n_pulse = 0;
      for (int i = 0; i < 8; i++) begin
         keys[2*4+3] = (i % 2 == 0);
         tick(5);
      end
      check("bounce_none", n_pulse, 0);
      keys[2*4+3] = 1'b1;
      tick(100);
      check("e_count", n_pulse, 1);
      check("e_code", seen_code, 4'hE);
      keys = 16'h0;
      tick(60);

      // short glitch on "A"
      n_pulse = 0;
      keys[3*4+0] = 1'b1;
      tick(10);
      keys = 16'h0;
      tick(60);
      check("glitch_none", n_pulse, 0);

      // "7" held, then "3" added; release "7"
      n_pulse = 0;
      keys[0*4+2] = 1'b1;
      tick(80);
      keys[2*4+0] = 1'b1;
      tick(80);
      check("two_count", n_pulse, 1);
      check("two_code7", seen_code, 4'h7);
      keys[0*4+2] = 1'b0;
      tick(120);
      check("two_count2", n_pulse, 2);
      check("two_code3", seen_code, 4'h3);
      keys = 16'h0;
      tick(60);

      // reset while "D" is held
      keys[3*4+3] = 1'b1;
      tick(80);
      check("d_held", kif.key_held, 1'b1);
      reset = 1'b1;
      tick(1);
      check("d_rst_held", kif.key_held, 1'b0);
      check("d_rst_col", kif.col, 4'b1110);
      check("d_rst_code", kif.key_code, 4'h0);
      reset = 1'b0;
      n_pulse = 0;
      tick(100);
      check("d_again_count", n_pulse, 1);
      check("d_again_code", seen_code, 4'hD);
      keys = 16'h0;
      tick(60);

      // randomized presses, bounces, overlaps and resets against the model
      for (int it = 0; it < 30; it++) begin
         k = $urandom_range(0, 15);
         mode = $urandom_range(0, 3);
         keys[k] = 1'b1;
         if (mode == 0) begin
            repeat ($urandom_range(1, 6)) begin
               tick($urandom_range(1, 8));
               keys[k] = ~keys[k];
            end
            keys[k] = 1'b1;
         end
         tick($urandom_range(1, 90));
         if (mode == 1) begin
            keys[$urandom_range(0, 15)] = 1'b1;
            tick($urandom_range(1, 60));
         end
         if (mode == 2 && $urandom_range(0, 1) == 1) begin
            reset = 1'b1;
            tick(1);
            reset = 1'b0;
         end
         keys = 16'h0;
         tick($urandom_range(5, 50));
      end
      tick(60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
